// File: rtl/spi_slave_cmd_if.sv
// SPI slave front end: assembles MSB-first frames into 10-bit RAM command words
// and shifts one RAM read word back out on miso for each read-data frame.
module spi_slave_cmd_if #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  a_rst_n,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic [2:0]            state_dbg,
  output logic                  addr_held_dbg,
  output logic                  tx_done_dbg
);

  localparam int FW  = DATA_WIDTH + 2;
  localparam int CW  = $clog2(FW + 1);
  localparam int TCW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         bit_cnt;
  logic [FW-1:0]         shift_q;
  logic [DATA_WIDTH-2:0] tx_shift;
  logic [TCW-1:0]        tx_cnt;
  logic                  addr_held;
  logic                  tx_done;

  logic in_frame, frame_last, frame_done, tx_start;

  // Handshake: rx_valid is a one-cycle strobe with no ready; the RAM must take
  // rx_data in that cycle. tx_valid is level-qualified and accepted once per frame.
  always_comb begin
    in_frame   = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
    frame_last = in_frame && (bit_cnt == CW'(FW - 1));
    frame_done = (bit_cnt == CW'(FW));
    tx_start   = (state == READ_DATA) && frame_done && !tx_done && tx_valid;
  end

  always_comb begin
    state_next = state;
    if (ss_n) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = CHK_CMD;
        CHK_CMD: begin
          if (!mosi)          state_next = WRITE;
          else if (addr_held) state_next = READ_DATA;
          else                state_next = READ_ADD;
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      bit_cnt   <= '0;
      shift_q   <= '0;
      tx_shift  <= '0;
      tx_cnt    <= '0;
      addr_held <= 1'b0;
      tx_done   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      miso      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (ss_n) begin
        // Abort or end of frame: drop partial data, keep rx_data and addr_held.
        bit_cnt  <= '0;
        shift_q  <= '0;
        tx_shift <= '0;
        tx_cnt   <= '0;
        miso     <= 1'b0;
      end else begin
        if (state == CHK_CMD) begin
          shift_q <= {{(FW-1){1'b0}}, mosi};
          bit_cnt <= CW'(1);
        end else if (in_frame && !frame_done) begin
          shift_q <= {shift_q[FW-2:0], mosi};
          bit_cnt <= bit_cnt + CW'(1);
          if (frame_last) begin
            rx_data  <= {shift_q[FW-2:0], mosi};
            rx_valid <= 1'b1;
            if (state == READ_ADD)  addr_held <= 1'b1;
            if (state == READ_DATA) addr_held <= 1'b0;
          end
        end

        if (tx_start) begin
          miso     <= tx_data[DATA_WIDTH-1];
          tx_shift <= tx_data[DATA_WIDTH-2:0];
          tx_cnt   <= TCW'(DATA_WIDTH - 1);
          tx_done  <= 1'b1;
        end else if (tx_cnt != '0) begin
          miso     <= tx_shift[DATA_WIDTH-2];
          tx_shift <= {tx_shift[DATA_WIDTH-3:0], 1'b0};
          tx_cnt   <= tx_cnt - TCW'(1);
        end else begin
          miso <= 1'b0;
        end
      end
      if (state == IDLE) tx_done <= 1'b0;
    end
  end

  assign state_dbg     = state;
  assign addr_held_dbg = addr_held;
  assign tx_done_dbg   = tx_done;

endmodule

// File: tb/tb_spi_slave_cmd_if.sv
// Bench for spi_slave_cmd_if: directed frames, rx words checked by a queue-based
// monitor, miso streams and debug state checked against hand-computed values.
module tb_spi_slave_cmd_if;

  localparam int DW = 8;
  localparam logic [2:0] S_IDLE = 3'd0, S_CHK = 3'd1, S_WR = 3'd2,
                         S_RA = 3'd3, S_RD = 3'd4;

  logic          clk = 1'b0;
  logic          a_rst_n = 1'b0;
  logic          ss_n = 1'b1;
  logic          mosi = 1'b0;
  logic          miso;
  logic [DW+1:0] rx_data;
  logic          rx_valid;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic [2:0]    state_dbg;
  logic          addr_held_dbg;
  logic          tx_done_dbg;

  int vectors = 0;
  int errors = 0;
  logic [DW+1:0] exp_q[$];
  logic          miso_any;
  logic [15:0]   miso_got;

  spi_slave_cmd_if #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .state_dbg(state_dbg), .addr_held_dbg(addr_held_dbg), .tx_done_dbg(tx_done_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // monitor: every rx_valid pulse must match the next expected word
  always @(negedge clk) begin
    if (a_rst_n && rx_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: got rx_data=0x%03h, required no rx_valid", rx_data);
      end else begin
        logic [DW+1:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          errors++;
          $display("FAIL rx_word: got 0x%03h, required 0x%03h", rx_data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // full frame: E0 then 10 bits; leaves ss_n low just after E10
  task automatic send_frame(input logic [DW+1:0] w, input logic [2:0] exp_st, input string nm);
    exp_q.push_back(w);
    ss_n = 1'b0;
    step();
    chk({nm, "_chk_cmd"}, 32'(state_dbg), 32'(S_CHK));
    for (int i = DW + 1; i >= 0; i--) begin
      mosi = w[i];
      step();
      miso_any = miso_any | miso;
    end
    chk({nm, "_state"}, 32'(state_dbg), 32'(exp_st));
  endtask

  // partial frame: E0, nbits bits, then ss_n high on the following edge
  task automatic abort_frame(input logic [DW+1:0] w, input int nbits);
    ss_n = 1'b0;
    step();
    for (int i = 0; i < nbits; i++) begin
      mosi = w[DW+1-i];
      step();
    end
    ss_n = 1'b1;
    step();
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    mosi = 1'b0;
    step();
    step();
  endtask

  initial begin
    // reset
    a_rst_n = 1'b0;
    step();
    step();
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("rst_addr_held", 32'(addr_held_dbg), 32'h0);
    a_rst_n = 1'b1;
    step();

    // write address
    miso_any = 1'b0;
    send_frame(10'h005, S_WR, "wr_addr");
    chk("wr_addr_miso", 32'(miso_any), 32'h0);
    end_frame();

    // write data with spurious tx_valid
    miso_any = 1'b0;
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    send_frame(10'h1A5, S_WR, "wr_data");
    for (int i = 0; i < 3; i++) begin
      step();
      miso_any = miso_any | miso;
    end
    tx_valid = 1'b0;
    chk("wr_spur_miso", 32'(miso_any), 32'h0);
    chk("wr_spur_tx_done", 32'(tx_done_dbg), 32'h0);
    chk("wr_addr_held", 32'(addr_held_dbg), 32'h0);
    end_frame();

    // read address
    send_frame(10'h205, S_RA, "rd_addr");
    chk("rd_addr_held", 32'(addr_held_dbg), 32'h1);
    end_frame();

    // read data, RAM returns 0xA5 with tx_valid held 5 cycles
    send_frame(10'h3C3, S_RD, "rd_data");
    chk("rd_data_addr_held", 32'(addr_held_dbg), 32'h0);
    tx_data = 8'hA5;
    for (int c = 0; c < 16; c++) begin
      tx_valid = (c < 5);
      step();
      miso_got[15-c] = miso;
    end
    tx_valid = 1'b0;
    chk("rd_miso_stream", 32'(miso_got), 32'hA500);
    chk("rd_tx_done", 32'(tx_done_dbg), 32'h1);
    end_frame();
    chk("idle_tx_done_clr", 32'(tx_done_dbg), 32'h0);

    // abort a read-address frame after 6 bits
    abort_frame(10'h2F0, 6);
    chk("abort_state", 32'(state_dbg), 32'(S_IDLE));
    chk("abort_addr_held", 32'(addr_held_dbg), 32'h0);
    chk("abort_rx_data", 32'(rx_data), 32'h3C3);
    step();

    // abort on the completing edge: no rx_valid
    abort_frame(10'h0FF, 9);
    chk("late_abort_rx_data", 32'(rx_data), 32'h3C3);
    step();

    // next read frame re-enters READ_ADD
    send_frame(10'h2AA, S_RA, "rd_addr2");
    chk("rd_addr2_held", 32'(addr_held_dbg), 32'h1);
    end_frame();

    // read data, reset during miso bit 3 of 0x5A
    send_frame(10'h300, S_RD, "rd_data2");
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    chk("tx_bit7", 32'(miso), 32'h0);
    step();
    chk("tx_bit6", 32'(miso), 32'h1);
    step();
    step();
    step();
    chk("tx_bit3", 32'(miso), 32'h1);
    a_rst_n = 1'b0;
    #1;
    chk("arst_miso", 32'(miso), 32'h0);
    chk("arst_rx_valid", 32'(rx_valid), 32'h0);
    chk("arst_rx_data", 32'(rx_data), 32'h0);
    chk("arst_state", 32'(state_dbg), 32'(S_IDLE));
    ss_n = 1'b1;
    step();
    a_rst_n = 1'b1;
    step();

    send_frame(10'h201, S_RA, "post_rst");
    end_frame();

    step();
    chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_cmd_if.md
Name: spi_slave_cmd_if

Overview:
- Serial front end that turns SPI frames into 10-bit RAM command words.
- Receives MSB-first frames on mosi, assembles rx_data[9:0] and pulses rx_valid toward the single-port RAM.
- For read-data commands, captures the RAM's tx_data on tx_valid and shifts it out on miso.
- The SPI bit clock is the system clock clk. Each MOSI bit is sampled on a clk rising edge while ss_n is low.

Parameters:
- DATA_WIDTH, 8, width of the memory word and address field. The frame length is DATA_WIDTH+2.

Ports:
- clk  input  1  system clock, also the SPI bit clock; all logic on rising edge
- a_rst_n  input  1  asynchronous active-low reset
- ss_n  input  1  slave select, active low; high aborts or ends a frame
- mosi  input  1  serial data in, MSB first
- miso  output  1  serial data out, registered, MSB first
- rx_data  output  DATA_WIDTH+2  assembled command word: [9:8] opcode, [7:0] address or data
- rx_valid  output  1  one-cycle pulse when rx_data is complete
- tx_data  input  DATA_WIDTH  read word from RAM
- tx_valid  input  1  RAM read data valid; may stay high for several cycles

Behaviour:
- Reset (a_rst_n low, asynchronous):
  - state=IDLE; rx_data=0; rx_valid=0; miso=0.
  - Shift registers, bit counter, addr_held flag and tx_done flag all cleared.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Any state, ss_n sampled high: next state is IDLE.
  - Counters cleared, miso=0.
  - No rx_valid for an incomplete frame; rx_data keeps its last value; addr_held unchanged.
- IDLE, ss_n sampled low at edge E0: go to CHK_CMD.
- CHK_CMD, edge E1: mosi is bit 9. It is shifted in and selects the next state:
  - 0: WRITE.
  - 1 and addr_held=0: READ_ADD.
  - 1 and addr_held=1: READ_DATA.
- WRITE, READ_ADD and READ_DATA each shift bits 8..0 on edges E2..E10.
- Edge E10:
  - rx_data <= {shift[8:0], mosi}; rx_valid=1 for exactly that cycle.
  - The bit counter saturates.
  - Further mosi bits are ignored until ss_n goes high.
- addr_held flag:
  - Set on the E10 edge of a READ_ADD frame.
  - Cleared on the E10 edge of a READ_DATA frame.
  - Not affected by WRITE frames or aborts.
  - An aborted READ_DATA frame leaves it set.
- Read data return (READ_DATA state only, after its rx_valid, while tx_done=0):
  - First edge Ek where tx_valid is sampled high: miso <= tx_data[7]; tx_data[6:0] loaded into the tx shift register; tx_done set.
  - Edges Ek+1..Ek+7 output bits 6..0.
  - Edge Ek+8: miso returns to 0.
  - tx_valid is ignored while tx_done=1, so exactly one word is sent per frame.
  - tx_done clears in IDLE.
- tx_valid arriving in any other state, or before the frame's rx_valid, is ignored.
- miso is 0 whenever no read word is being shifted.
- No handshake back-pressure: the RAM must accept rx_valid in the same cycle.
- Minimum latency:
  - ss_n fall to rx_valid: 11 edges (E0..E10).
  - RAM return: tx_valid one cycle after rx_valid, so the first miso bit is valid after edge E11.
- Simultaneous events:
  - ss_n high on the same edge that would complete a frame: the abort wins, no rx_valid.
  - Asynchronous reset overrides everything, including mid-transmit.

Test Plan:
- Write address: ss_n low, mosi 00_0000_0101 -> rx_data=0x005, single rx_valid pulse at E10, state WRITE, miso stays 0.
- Write data: next frame 01_1010_0101 -> rx_data=0x1A5, rx_valid once, addr_held unchanged (0).
- Read address then read data:
  - Frame 10_0000_0101 -> state READ_ADD, rx_data=0x205, addr_held=1.
  - Frame 11_xxxx_xxxx -> state READ_DATA, rx_data[9:8]=11.
  - RAM returns tx_data=0xA5 with tx_valid held high 5 cycles -> miso 1,0,1,0,0,1,0,1 on 8 consecutive cycles then 0; addr_held=0; no second transmission.
- Abort:
  - ss_n high after 6 bits of a READ_ADD frame -> no rx_valid, state IDLE, addr_held stays 0.
  - Next frame starting with 1 enters READ_ADD again.
- Reset mid-transmit: assert a_rst_n low during miso bit 3 of a read word -> miso=0, rx_valid=0, rx_data=0 immediately; after release, ss_n low enters CHK_CMD and a bit-9=1 frame goes to READ_ADD.
- Spurious tx_valid=1 during a WRITE frame -> miso stays 0 and tx_done stays 0.
